combine_engine_n: RTL

- Parametrised, register-mapped N-input combiner.
- Software pushes words into NUM_IN input FIFOs over a simple write port.
- On each programmable interval tick, if every input has data and the output has room, one word is popped from each input, combined by a selectable operator, and pushed to an output FIFO.
- Software pops results and reads status over the read port. Successor to the fixed 2-input OR / fixed-tick combiner.

---
 rtl/combine_engine_n_if.sv | 30 +++
 rtl/combine_engine_n.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/combine_engine_n_if.sv
// Register bus for combine_engine_n.
//   write_address/write_data/write_en : register write strobe (master -> slave)
//   write_rdy                         : always ready (slave -> master)
//   read_address/read_en              : register read strobe (master -> slave)
//   read_data/read_valid              : registered read result, valid one cycle later
//   read_rdy                          : always ready (slave -> master)
interface combine_engine_n_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic              write_rdy;
    logic [ADDR_W-1:0] read_address;
    logic              read_en;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              read_rdy;

    modport master (
        output write_address, write_data, write_en, read_address, read_en,
        input  write_rdy, read_data, read_valid, read_rdy
    );

    modport slave (
        input  write_address, write_data, write_en, read_address, read_en,
        output write_rdy, read_data, read_valid, read_rdy
    );
endinterface

// File: rtl/combine_engine_n.sv
// Register-mapped N-input combiner. Software pushes words into NUM_IN input
// FIFOs; on each interval tick, when every input has data and the output has
// room, one word from each input is combined (OR/AND/XOR/ADD) into the output
// FIFO, which software drains through the POP register.
// Ports:
//   CLK, RST       : clock (rising edge), asynchronous active-high reset
//   bus            : register read/write port (slave side)
//   fire           : one-cycle pulse the cycle after a combine
//   out_not_empty  : output FIFO holds at least one word
module combine_engine_n #(
    parameter int DATA_W       = 8,
    parameter int NUM_IN       = 2,
    parameter int IN_DEPTH     = 2,
    parameter int OUT_DEPTH    = 2,
    parameter int ADDR_W       = 4,
    parameter int DEF_INTERVAL = 50
) (
    input  logic              CLK,
    input  logic              RST,
    combine_engine_n_if.slave bus,
    output logic              fire,
    output logic              out_not_empty
);
    localparam int IP_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int IC_W = $clog2(IN_DEPTH + 1);
    localparam int OP_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OC_W = $clog2(OUT_DEPTH + 1);

    typedef logic [DATA_W-1:0] word_t;

    word_t           in_mem_q  [NUM_IN][IN_DEPTH];
    word_t           in_mem_d  [NUM_IN][IN_DEPTH];
    logic [IP_W-1:0] in_rd_q   [NUM_IN];
    logic [IP_W-1:0] in_rd_d   [NUM_IN];
    logic [IP_W-1:0] in_wr_q   [NUM_IN];
    logic [IP_W-1:0] in_wr_d   [NUM_IN];
    logic [IC_W-1:0] in_cnt_q  [NUM_IN];
    logic [IC_W-1:0] in_cnt_d  [NUM_IN];
    word_t           out_mem_q [OUT_DEPTH];
    word_t           out_mem_d [OUT_DEPTH];
    logic [OP_W-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
    logic [OC_W-1:0] out_cnt_q, out_cnt_d;
    logic [2:0]      ctrl_q, ctrl_d;
    word_t           interval_q, interval_d;
    word_t           tick_cnt_q, tick_cnt_d;
    word_t           drop_q, drop_d;
    word_t           read_data_q, read_data_d;
    logic            read_valid_q;
    logic            fire_q, fire_d;

    logic              wr_ctrl, wr_intv, wr_clear, pop_req, pop_ok;
    logic              tick, combine, drop_evt, out_ne, out_full;
    logic [NUM_IN-1:0] push_req, push_ok, in_ne, in_full;
    word_t             result, rdata;

    function automatic logic [IP_W-1:0] in_next(input logic [IP_W-1:0] p);
        return (p == IP_W'(IN_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [OP_W-1:0] out_next(input logic [OP_W-1:0] p);
        return (p == OP_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // All decisions below use state at the start of the cycle.
    always_comb begin
        wr_ctrl  = bus.write_en && (bus.write_address == ADDR_W'(0));
        wr_intv  = bus.write_en && (bus.write_address == ADDR_W'(1));
        wr_clear = bus.write_en && (bus.write_address == ADDR_W'(2));
        pop_req  = bus.read_en  && (bus.read_address  == ADDR_W'(3));
        for (int i = 0; i < NUM_IN; i++) begin
            in_ne[i]    = (in_cnt_q[i] != '0);
            in_full[i]  = (in_cnt_q[i] == IC_W'(IN_DEPTH));
            push_req[i] = bus.write_en && (bus.write_address == ADDR_W'(8 + i));
            push_ok[i]  = push_req[i] && !in_full[i];
        end
        drop_evt = |(push_req & in_full);
        out_ne   = (out_cnt_q != '0);
        out_full = (out_cnt_q == OC_W'(OUT_DEPTH));
        tick     = (tick_cnt_q == interval_q);
        // No pass-through: a full output blocks even with a same-cycle POP.
        combine  = ctrl_q[2] && tick && (&in_ne) && !out_full;
        pop_ok   = pop_req && out_ne;
    end

    always_comb begin
        result = in_mem_q[0][in_rd_q[0]];
        for (int i = 1; i < NUM_IN; i++) begin
            case (ctrl_q[1:0])
                2'd0:    result = result | in_mem_q[i][in_rd_q[i]];
                2'd1:    result = result & in_mem_q[i][in_rd_q[i]];
                2'd2:    result = result ^ in_mem_q[i][in_rd_q[i]];
                default: result = result + in_mem_q[i][in_rd_q[i]];
            endcase
        end
    end

    always_comb begin
        in_mem_d  = in_mem_q;
        in_rd_d   = in_rd_q;
        in_wr_d   = in_wr_q;
        in_cnt_d  = in_cnt_q;
        out_mem_d = out_mem_q;
        out_rd_d  = out_rd_q;
        out_wr_d  = out_wr_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (push_ok[i]) begin
                in_mem_d[i][in_wr_q[i]] = bus.write_data;
                in_wr_d[i]              = in_next(in_wr_q[i]);
            end
            if (combine) begin
                in_rd_d[i] = in_next(in_rd_q[i]);
            end
            in_cnt_d[i] = in_cnt_q[i] + IC_W'(push_ok[i]) - IC_W'(combine);
        end
        if (combine) begin
            out_mem_d[out_wr_q] = result;
            out_wr_d            = out_next(out_wr_q);
        end
        if (pop_ok) begin
            out_rd_d = out_next(out_rd_q);
        end
        out_cnt_d  = out_cnt_q + OC_W'(combine) - OC_W'(pop_ok);
        ctrl_d     = wr_ctrl ? bus.write_data[2:0] : ctrl_q;
        interval_d = wr_intv ? bus.write_data : interval_q;
        tick_cnt_d = (tick || wr_intv) ? '0 : tick_cnt_q + 1'b1;
        drop_d     = (drop_evt && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
        fire_d     = combine;
        // CLEAR wins over any same-cycle push, POP or combine.
        if (wr_clear) begin
            for (int i = 0; i < NUM_IN; i++) begin
                in_rd_d[i]  = '0;
                in_wr_d[i]  = '0;
                in_cnt_d[i] = '0;
            end
            out_rd_d   = '0;
            out_wr_d   = '0;
            out_cnt_d  = '0;
            tick_cnt_d = '0;
            drop_d     = '0;
            fire_d     = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.read_address)
            ADDR_W'(0): rdata = DATA_W'(ctrl_q);
            ADDR_W'(1): rdata = interval_q;
            ADDR_W'(2): begin
                rdata[NUM_IN-1:0] = in_ne;
                rdata[NUM_IN]     = out_ne;
                rdata[NUM_IN+1]   = out_full;
            end
            ADDR_W'(3): rdata = (out_ne && !wr_clear) ? out_mem_q[out_rd_q] : '0;
            ADDR_W'(4): rdata = DATA_W'(out_cnt_q);
            ADDR_W'(5): rdata = drop_q;
            default: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (bus.read_address == ADDR_W'(8 + i)) begin
                        rdata = DATA_W'(in_cnt_q[i]);
                    end
                end
            end
        endcase
        read_data_d = bus.read_en ? rdata : read_data_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_IN; i++) begin
                for (int j = 0; j < IN_DEPTH; j++) begin
                    in_mem_q[i][j] <= '0;
                end
                in_rd_q[i]  <= '0;
                in_wr_q[i]  <= '0;
                in_cnt_q[i] <= '0;
            end
            for (int j = 0; j < OUT_DEPTH; j++) begin
                out_mem_q[j] <= '0;
            end
            out_rd_q     <= '0;
            out_wr_q     <= '0;
            out_cnt_q    <= '0;
            ctrl_q       <= 3'b100;
            interval_q   <= DATA_W'(DEF_INTERVAL);
            tick_cnt_q   <= '0;
            drop_q       <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            fire_q       <= 1'b0;
        end else begin
            in_mem_q     <= in_mem_d;
            in_rd_q      <= in_rd_d;
            in_wr_q      <= in_wr_d;
            in_cnt_q     <= in_cnt_d;
            out_mem_q    <= out_mem_d;
            out_rd_q     <= out_rd_d;
            out_wr_q     <= out_wr_d;
            out_cnt_q    <= out_cnt_d;
            ctrl_q       <= ctrl_d;
            interval_q   <= interval_d;
            tick_cnt_q   <= tick_cnt_d;
            drop_q       <= drop_d;
            read_data_q  <= read_data_d;
            read_valid_q <= bus.read_en;
            fire_q       <= fire_d;
        end
    end

    assign bus.write_rdy  = 1'b1;
    assign bus.read_rdy   = 1'b1;
    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
    assign fire           = fire_q;
    assign out_not_empty  = out_ne;
endmodule
